// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared console encodings and defaults for the TX arbiter and DMA path
package console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BURST  = 2'd2
    } tx_state_e;

    localparam logic [7:0] HEADER_TAG = 8'h80;

    localparam int DEF_NUM_REQ      = 3;
    localparam int DEF_MAX_BURST    = 64;
    localparam int DEF_IDLE_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDXW-1:0]    idx_o,
    output logic               valid_o
);

    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        // Walk offsets 1..NUM_REQ so the previous owner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid_o && (i == cand) && req_i[i]) begin
                    valid_o  = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/console_tx_arbiter.sv
// rtl/console_tx_arbiter.sv - merges requester byte streams into one console stream with per-burst headers
module console_tx_arbiter
    import console_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     in_valid,
    input  logic [8*NUM_REQ-1:0]   in_data,
    input  logic [NUM_REQ-1:0]     in_last,
    output logic [NUM_REQ-1:0]     in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [31:0]            bytes_sent
);

    localparam int IDXW = $clog2(NUM_REQ);

    tx_state_e          state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0]    gidx_q, gidx_d;
    logic [IDXW-1:0]    last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [7:0]         pcnt_q, pcnt_d;
    logic [7:0]         tcnt_q, tcnt_d;
    logic [31:0]        bytes_q;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDXW-1:0]    rr_idx;
    logic               rr_valid;

    logic               out_fire;
    logic               out_free;
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr (
        .req_i   (in_valid),
        .last_i  (last_q),
        .gnt_o   (rr_gnt),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    assign out_fire = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;
    assign g_valid  = |(in_valid & grant_q);
    assign g_last   = |(in_last & grant_q);

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_data = g_data | in_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        pcnt_d      = pcnt_q;
        tcnt_d      = tcnt_q;
        in_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (en && rr_valid) begin
                    grant_d = rr_gnt;
                    gidx_d  = rr_idx;
                    last_d  = rr_idx;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER_TAG | 8'(gidx_q);
                    pcnt_d      = '0;
                    tcnt_d      = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                in_ready = grant_q & {NUM_REQ{out_free}};
                if (g_valid) begin
                    // A stalled-but-valid requester is not idle, so the timeout restarts.
                    tcnt_d = '0;
                    if (out_free) begin
                        out_valid_d = 1'b1;
                        out_data_d  = g_data;
                        pcnt_d      = pcnt_q + 8'd1;
                        if (g_last || (pcnt_q + 8'd1 == 8'(MAX_BURST))) begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_q + 8'd1 == 8'(IDLE_TIMEOUT)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_q      <= IDXW'(NUM_REQ - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pcnt_q      <= '0;
            tcnt_q      <= '0;
            bytes_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pcnt_q      <= pcnt_d;
            tcnt_q      <= tcnt_d;
            bytes_q     <= bytes_q + {31'd0, out_fire};
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign grant      = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_console_tx_arbiter.sv
// tb/tb_console_tx_arbiter.sv - directed self-checking bench for console_tx_arbiter
module tb_console_tx_arbiter;

    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [NR-1:0]   in_valid;
    logic [8*NR-1:0] in_data;
    logic [NR-1:0]   in_last;
    logic [NR-1:0]   in_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_ready;
    logic [NR-1:0]   grant;
    logic            busy;
    logic [31:0]     bytes_sent;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [7:0] outq[$];
    logic [7:0] expq[$];

    console_tx_arbiter #(
        .NUM_REQ      (NR),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .grant      (grant),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        in_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        in_data  = '0;
        in_last  = '0;
        if (q0.size() != 0) begin e = q0[0]; in_data[7:0]   = e[7:0]; in_last[0] = e[8]; end
        if (q1.size() != 0) begin e = q1[0]; in_data[15:8]  = e[7:0]; in_last[1] = e[8]; end
        if (q2.size() != 0) begin e = q2[0]; in_data[23:16] = e[7:0]; in_last[2] = e[8]; end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        if (r == 0) q0.push_back({last, d});
        else if (r == 1) q1.push_back({last, d});
        else q2.push_back({last, d});
    endtask

    // Sample handshakes mid-cycle, then retire accepted bytes just after the edge.
    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        if (out_valid && out_ready) outq.push_back(out_data);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        if (acc[2]) void'(q2.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        outq.delete();
        drive();
    endtask

    task automatic run_until_idle(input int max_cyc, input string tag);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            step();
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) && !busy && !out_valid;
        end
        check_eq({tag, "_settled"}, {31'd0, done}, 32'd1);
    endtask

    task automatic expect_seq(input string tag);
        logic [31:0] got;
        check_eq({tag, "_len"}, outq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            got = (i < outq.size()) ? {24'd0, outq[i]} : 32'hFFFF_FFFF;
            check_eq($sformatf("%s[%0d]", tag, i), got, {24'd0, expq[i]});
        end
        expq.delete();
    endtask

    task automatic wait_byte(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        while (!(out_valid && out_data == b) && n < 30) begin
            step();
            n++;
        end
        check_eq({tag, "_seen"}, {31'd0, out_valid && out_data == b}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; out_ready = 1'b1;
        in_valid = '0; in_data = '0; in_last = '0;
        do_reset();

        // Reset state and enable gating
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_grant", {29'd0, grant}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_bytes", bytes_sent, 32'd0);
        check_eq("rst_in_ready", {29'd0, in_ready}, 32'd0);
        en = 1'b0;
        push(0, 8'h65, 1'b1);
        drive();
        repeat (4) step();
        check_eq("en_low_busy", {31'd0, busy}, 32'd0);
        check_eq("en_low_grant", {29'd0, grant}, 32'd0);
        en = 1'b1;
        run_until_idle(40, "en_run");
        expq = '{8'h80, 8'h65};
        expect_seq("en_seq");
        check_eq("en_bytes", bytes_sent, 32'd2);

        // Sole requester 1 sends "hi\n"
        do_reset();
        push(1, 8'h68, 1'b0); push(1, 8'h69, 1'b0); push(1, 8'h0A, 1'b1);
        drive();
        run_until_idle(60, "hi");
        expq = '{8'h81, 8'h68, 8'h69, 8'h0A};
        expect_seq("hi_seq");
        check_eq("hi_bytes", bytes_sent, 32'd4);
        check_eq("hi_grant_idle", {29'd0, grant}, 32'd0);

        // Requesters 0 and 2 alternate 2-byte messages
        do_reset();
        push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1); push(0, 8'h63, 1'b0); push(0, 8'h64, 1'b1);
        push(2, 8'h78, 1'b0); push(2, 8'h79, 1'b1); push(2, 8'h7A, 1'b0); push(2, 8'h77, 1'b1);
        drive();
        run_until_idle(100, "rr");
        expq = '{8'h80, 8'h61, 8'h62, 8'h82, 8'h78, 8'h79, 8'h80, 8'h63, 8'h64, 8'h82, 8'h7A, 8'h77};
        expect_seq("rr_seq");

        // 10 bytes with no last, MAX_BURST of 4
        do_reset();
        for (int i = 0; i < 10; i++) push(0, 8'h30 + 8'(i), 1'b0);
        drive();
        run_until_idle(120, "burst");
        expq = '{8'h80, 8'h30, 8'h31, 8'h32, 8'h33, 8'h80, 8'h34, 8'h35, 8'h36, 8'h37, 8'h80, 8'h38, 8'h39};
        expect_seq("burst_seq");
        check_eq("burst_bytes", bytes_sent, 32'd13);

        // Downstream stall for 5 cycles mid-burst
        do_reset();
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b0); push(1, 8'h44, 1'b1);
        drive();
        wait_byte(8'h42, "stall");
        out_ready = 1'b0;
        drive();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("stall_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("stall_data_%0d", i), {24'd0, out_data}, 32'h42);
            check_eq($sformatf("stall_in_ready_%0d", i), {29'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        run_until_idle(60, "stall");
        expq = '{8'h81, 8'h41, 8'h42, 8'h43, 8'h44};
        expect_seq("stall_seq");
        check_eq("stall_bytes", bytes_sent, 32'd5);

        // Idle timeout hands the grant on to a waiting requester
        do_reset();
        push(1, 8'h70, 1'b0);
        push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b1);
        drive();
        run_until_idle(80, "tmo");
        push(1, 8'h73, 1'b1);
        drive();
        run_until_idle(40, "tmo_again");
        expq = '{8'h81, 8'h70, 8'h82, 8'h71, 8'h72, 8'h81, 8'h73};
        expect_seq("tmo_seq");

        // Reset asserted mid-burst
        do_reset();
        push(1, 8'h75, 1'b0); push(1, 8'h76, 1'b0); push(1, 8'h77, 1'b1);
        drive();
        wait_byte(8'h75, "mrst");
        check_eq("mrst_in_burst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        check_eq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_grant", {29'd0, grant}, 32'd0);
        check_eq("mrst_bytes", bytes_sent, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        outq.delete();
        push(0, 8'h6B, 1'b1);
        push(1, 8'h6A, 1'b1);
        drive();
        run_until_idle(60, "mrst_after");
        expq = '{8'h80, 8'h6B, 8'h81, 8'h6A};
        expect_seq("mrst_seq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/console_tx_arbiter.md
CONSOLE_TX_ARBITER -- requirements
Module: console_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning the number of byte-stream requesters (legal range 2..4).
REQ-002 SHALL have parameter MAX_BURST, default 64, meaning the maximum payload bytes per grant (legal range 1..255).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 16, meaning consecutive cycles a granted requester may hold in_valid low before losing its grant (legal range 1..255).
REQ-004 SHALL have input clk, 1 bit: the clock.
REQ-005 SHALL have input rst_n, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have input en, 1 bit: arbitration enable; when low, no new grant is issued.
REQ-007 SHALL have input in_valid, NUM_REQ bits: per-requester byte valid.
REQ-008 SHALL have input in_data, 8*NUM_REQ bits: per-requester byte; requester i uses bits [8i+7:8i]; payload is 7-bit ASCII.
REQ-009 SHALL have input in_last, NUM_REQ bits: per-requester end-of-message flag, qualified by in_valid.
REQ-010 SHALL have output in_ready, NUM_REQ bits: per-requester byte accept.
REQ-011 SHALL have output out_valid, 1 bit: output byte valid (drives the console output FIFO wr_en).
REQ-012 SHALL have output out_data, 8 bits: output byte.
REQ-013 SHALL have input out_ready, 1 bit: downstream FIFO not full.
REQ-014 SHALL have output grant, NUM_REQ bits: one-hot current owner; all zero when idle.
REQ-015 SHALL have output busy, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have output bytes_sent, 32 bits: count of output handshakes (header and payload), wrapping modulo 2^32.

Function
REQ-017 SHALL implement states IDLE, HEADER and BURST.
REQ-018 SHALL, in IDLE with en high and any in_valid bit high, select a requester round-robin, starting the search at (last_grant+1) mod NUM_REQ, latch it into grant and go to HEADER.
REQ-019 SHALL, in HEADER, load out_data with 0x80|src_index and set out_valid when the output register is empty or is being consumed in that cycle, then go to BURST.
REQ-020 SHALL, in BURST, drive in_ready[g] = (!out_valid || out_ready) for granted requester g, hold all other in_ready bits low, and keep in_ready low in IDLE and HEADER.
REQ-021 SHALL present a byte accepted on cycle n (in_valid[g] && in_ready[g]) on out_data with out_valid on cycle n+1, which is a one-cycle latency.
REQ-022 SHALL hold out_valid and out_data stable while out_valid is high and out_ready is low, and clear out_valid after a handshake unless a new byte or header is loaded in the same cycle.
REQ-023 SHALL end the burst and return to IDLE on the first of: an accepted byte with in_last set; the payload count reaching MAX_BURST; or in_valid[g] low for IDLE_TIMEOUT consecutive BURST cycles.
REQ-024 SHALL clear the payload counter and timeout counter on each entry to BURST, and clear the timeout counter on every cycle in which in_valid[g] is high.
REQ-025 SHALL spend at least one cycle in IDLE between grants, so back-to-back bursts from a single sole requester are each preceded by a header.
REQ-026 SHALL let a burst already in progress complete normally when en falls, and stay in IDLE while en is low.
REQ-027 SHALL leave a pending out_valid byte held until it is consumed on return to IDLE, and SHALL NOT issue the next header until the output register is free.
REQ-028 SHALL increment bytes_sent on every out_valid && out_ready cycle.

Reset
REQ-029 SHALL, when rst_n is low at a clk edge, set the state to IDLE and clear out_valid, out_data, grant, in_ready, bytes_sent, the counters and last_grant (last_grant resets to NUM_REQ-1 so requester 0 wins first).
REQ-030 SHALL abandon a mid-burst reset without flushing, so the output byte in flight is dropped.

Structure
REQ-031 SHALL place the state encoding, HEADER_TAG (8'h80) and the parameter defaults in a shared package/include (console_pkg) also used by the console DMA path.
REQ-032 SHALL implement the round-robin selection as one sub-module, rr_arbiter (request vector plus last-grant pointer in; one-hot grant and index out, combinational).

Verification
REQ-033 SHALL verify that with only req1 sending "hi\n" (last on '\n') and out_ready=1, the output is 0x81,'h','i',0x0A, bytes_sent=4, and the block then returns to IDLE.
REQ-034 SHALL verify that with req0 and req2 both valid from reset, each sending 2-byte messages in a loop, the headers alternate 0x80,0x82,0x80 with no payload interleaving.
REQ-035 SHALL verify that with MAX_BURST=4 and req0 streaming 10 bytes with no last, the output is header, 4 bytes, header, 4 bytes, header, 2 bytes.
REQ-036 SHALL verify that when out_ready is held low for 5 cycles mid-burst, out_data remains stable, in_ready stays low and no byte is lost or duplicated.
REQ-037 SHALL verify that with IDLE_TIMEOUT=3, a granted req1 that drops in_valid for 3 cycles loses its grant, pending req2 receives header 0x82 next, and a later byte from req1 gets a new header.
REQ-038 SHALL verify that asserting rst_n low during BURST gives out_valid=0, grant=0 and bytes_sent=0 on the next cycle, and that the next grant goes to req0.
